// File: rtl/spectrum_pkg.sv
// Shared widths and the timing bundle carried alongside the spectrum RAM read.
package spectrum_pkg;
    localparam int BIN_AW  = 13;
    localparam int MAG_W   = 11;
    localparam int RGB_W   = 24;
    localparam int COORD_W = 12;

    localparam logic [BIN_AW-1:0] BIN_MAX = '1;

    typedef struct packed {
        logic               de;
        logic               hs;
        logic               vs;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               oob;
    } timing_t;
endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register used to realign video timing with RAM read data.
module video_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    // Shift one slot per clock; reset flushes every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/spectrum_plot_reader.sv
// Reads spectrum magnitudes per video column, draws a bar trace over a grid,
// and reports the peak bin of each frame at the following vsync.
module spectrum_plot_reader
    import spectrum_pkg::*;
#(
    parameter int          H_ACTIVE        = 1280,
    parameter int          PLOT_TOP        = 100,
    parameter int          PLOT_HEIGHT     = 512,
    parameter int          RAM_LAT         = 2,
    parameter int          GRID_PITCH_LOG2 = 6,
    parameter logic [23:0] TRACE_RGB       = 24'h00FF00,
    parameter logic [23:0] GRID_RGB        = 24'h404040,
    parameter logic [23:0] BG_RGB          = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [11:0] in_x,
    input  logic [11:0] in_y,
    input  logic [12:0] cfg_start_bin,
    input  logic [2:0]  cfg_step_log2,
    input  logic [3:0]  cfg_gain_shift,
    output logic [12:0] ram_addr,
    input  logic [10:0] ram_dout,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [23:0] out_rgb,
    output logic [12:0] peak_bin,
    output logic [10:0] peak_mag,
    output logic        peak_valid
);
    localparam int DLY_W = $bits(timing_t) + BIN_AW;
    localparam logic [12:0] ROW_TOP = 13'(PLOT_TOP);
    localparam logic [12:0] ROW_END = 13'(PLOT_TOP + PLOT_HEIGHT);
    localparam logic [12:0] MAG_CAP = 13'(PLOT_HEIGHT);
    localparam logic [COORD_W-1:0] GRID_MASK = COORD_W'((1 << GRID_PITCH_LOG2) - 1);

    // The column coordinate is 12 bits and the row distance must fit 11 bits.
    if (PLOT_HEIGHT > 2047 || RAM_LAT < 1 || H_ACTIVE > 4096) begin : g_bad_params
        $error("spectrum_plot_reader: unsupported parameter set");
    end

    logic        vs_prev_q, vs_rise;
    logic [12:0] start_q;
    logic [2:0]  step_q;
    logic [3:0]  gain_q;

    assign vs_rise = in_vs & ~vs_prev_q;

    // Shadow the config at frame start so mid-frame writes wait for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            start_q   <= '0;
            step_q    <= '0;
            gain_q    <= '0;
        end else begin
            vs_prev_q <= in_vs;
            if (vs_rise) begin
                start_q <= cfg_start_bin;
                step_q  <= cfg_step_log2;
                gain_q  <= cfg_gain_shift;
            end
        end
    end

    logic [19:0]       addr_raw;
    logic [BIN_AW-1:0] bin0;
    timing_t           tin;

    // Column-to-bin mapping; bins past the top of the RAM clamp and flag oob.
    always_comb begin
        tin      = '0;
        addr_raw = 20'(start_q) + (20'(in_x) << step_q);
        tin.oob  = addr_raw > 20'(BIN_MAX);
        bin0     = tin.oob ? BIN_MAX : addr_raw[BIN_AW-1:0];
        tin.de   = in_de;
        tin.hs   = in_hs;
        tin.vs   = in_vs;
        tin.x    = in_x;
        tin.y    = in_y;
    end

    logic [12:0] ram_addr_q;

    // Read address only moves on active pixels so blanking leaves it parked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ram_addr_q <= '0;
        else if (in_de) ram_addr_q <= bin0;
    end

    // One slot for the address register plus the RAM latency.
    logic [DLY_W-1:0]  dly_out;
    timing_t           pix;
    logic [BIN_AW-1:0] pix_bin;

    video_delay_line #(.DEPTH(RAM_LAT + 1), .WIDTH(DLY_W)) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din_i ({tin, bin0}),
        .dout_o(dly_out)
    );

    assign {pix, pix_bin} = dly_out;

    logic [MAG_W-1:0] mag_sh;
    logic [12:0]      mag_s, y_ext, r;
    logic             in_plot;
    logic [23:0]      rgb_d;

    // Colour pick: blanking, outside plot, oob, trace, grid, background.
    always_comb begin
        mag_sh  = ram_dout >> gain_q;
        mag_s   = (13'(mag_sh) > MAG_CAP) ? MAG_CAP : 13'(mag_sh);
        y_ext   = 13'(pix.y);
        in_plot = (y_ext >= ROW_TOP) && (y_ext < ROW_END);
        r       = ROW_END - 13'd1 - y_ext;
        rgb_d   = '0;
        if (!pix.de)                                       rgb_d = '0;
        else if (!in_plot || pix.oob)                      rgb_d = BG_RGB;
        else if (r < mag_s)                                rgb_d = TRACE_RGB;
        else if (r == '0 || (pix.x & GRID_MASK) == '0)     rgb_d = GRID_RGB;
        else                                               rgb_d = BG_RGB;
    end

    logic        out_de_q, out_hs_q, out_vs_q;
    logic [23:0] out_rgb_q;

    // Output register keeps syncs and colour on the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_de_q  <= 1'b0;
            out_hs_q  <= 1'b0;
            out_vs_q  <= 1'b0;
            out_rgb_q <= '0;
        end else begin
            out_de_q  <= pix.de;
            out_hs_q  <= pix.hs;
            out_vs_q  <= pix.vs;
            out_rgb_q <= rgb_d;
        end
    end

    logic              qual, armed_q, peak_valid_q;
    logic [MAG_W-1:0]  cur_mag_q, peak_mag_q;
    logic [BIN_AW-1:0] cur_bin_q, peak_bin_q;

    // Only the first plot row is sampled so each column counts once per frame.
    assign qual = pix.de && (pix.y == COORD_W'(PLOT_TOP)) && !pix.oob;

    // Track the frame maximum; publish it at the next vsync once a whole frame was seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q      <= 1'b0;
            cur_mag_q    <= '0;
            cur_bin_q    <= '0;
            peak_mag_q   <= '0;
            peak_bin_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            if (vs_rise) begin
                armed_q   <= 1'b1;
                cur_mag_q <= '0;
                cur_bin_q <= '0;
                if (armed_q) begin
                    peak_valid_q <= 1'b1;
                    peak_mag_q   <= cur_mag_q;
                    peak_bin_q   <= cur_bin_q;
                end
            end else if (qual && ram_dout > cur_mag_q) begin
                cur_mag_q <= ram_dout;
                cur_bin_q <= pix_bin;
            end
        end
    end

    assign ram_addr   = ram_addr_q;
    assign out_de     = out_de_q;
    assign out_hs     = out_hs_q;
    assign out_vs     = out_vs_q;
    assign out_rgb    = out_rgb_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
endmodule

// File: tb/tb_spectrum_plot_reader.sv
// Randomised bench for spectrum_plot_reader with a frame-level reference model.
module tb_spectrum_plot_reader;
    localparam int          PLOT_TOP    = 100;
    localparam int          PLOT_HEIGHT = 512;
    localparam int          GRID_PITCH  = 64;
    localparam logic [23:0] TRACE       = 24'h00FF00;
    localparam logic [23:0] GRID        = 24'h404040;
    localparam logic [23:0] BG          = 24'h000000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
    logic [11:0] in_x = '0, in_y = '0;
    logic [12:0] cfg_start_bin = '0;
    logic [2:0]  cfg_step_log2 = '0;
    logic [3:0]  cfg_gain_shift = '0;
    logic [12:0] ram_addr, peak_bin;
    logic [10:0] ram_dout, peak_mag;
    logic        out_de, out_hs, out_vs, peak_valid;
    logic [23:0] out_rgb;

    always #5 clk = ~clk;

    // Two-clock read latency RAM
    logic [10:0] mem [8192];
    logic [10:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= mem[ram_addr];
        rd2 <= rd1;
    end
    assign ram_dout = rd2;

    spectrum_plot_reader dut (
        .clk(clk), .rst_n(rst_n), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
        .in_x(in_x), .in_y(in_y), .cfg_start_bin(cfg_start_bin),
        .cfg_step_log2(cfg_step_log2), .cfg_gain_shift(cfg_gain_shift),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .out_de(out_de), .out_hs(out_hs),
        .out_vs(out_vs), .out_rgb(out_rgb), .peak_bin(peak_bin), .peak_mag(peak_mag),
        .peak_valid(peak_valid)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [26:0] exp_q[$];     // {de,hs,vs,rgb} per driven cycle, 4-cycle lag
    logic [12:0] exp_addr;
    logic [24:0] exp_pk;       // {valid,bin,mag}
    int m_start, m_step, m_gain, pub_bin, pub_mag;
    bit m_vs_prev, armed;
    int cand_b[$], cand_m[$];
    int xs[$];

    task automatic model_reset();
        exp_q.delete();
        repeat (4) exp_q.push_back('0);
        exp_addr = '0; exp_pk = '0;
        m_start = 0; m_step = 0; m_gain = 0; pub_bin = 0; pub_mag = 0;
        m_vs_prev = 0; armed = 0;
        cand_b.delete(); cand_m.delete();
    endtask

    function automatic int rx();
        return int'($urandom_range(0, 4095));
    endfunction

    // One clock: check outputs, drive new inputs, predict their effect.
    task automatic cyc(bit de, bit hs, bit vs, int x, int y);
        int a, bin, ms, r, bb, bm;
        bit oob, pv;
        logic [23:0] rgb;
        @(negedge clk);
        chk("pix", 32'({out_de, out_hs, out_vs, out_rgb}), 32'(exp_q.pop_front()));
        chk("addr", 32'(ram_addr), 32'(exp_addr));
        chk("peak", 32'({peak_valid, peak_bin, peak_mag}), 32'(exp_pk));
        in_de = de; in_hs = hs; in_vs = vs; in_x = 12'(x); in_y = 12'(y);

        a   = m_start + x * (1 << m_step);
        oob = a > 8191;
        bin = oob ? 8191 : a;
        if (!de) rgb = '0;
        else if (y < PLOT_TOP || y >= PLOT_TOP + PLOT_HEIGHT || oob) rgb = BG;
        else begin
            r  = PLOT_TOP + PLOT_HEIGHT - 1 - y;
            ms = int'(mem[bin]) / (1 << m_gain);
            if (ms > PLOT_HEIGHT) ms = PLOT_HEIGHT;
            if (r < ms) rgb = TRACE;
            else if (r == 0 || x % GRID_PITCH == 0) rgb = GRID;
            else rgb = BG;
        end
        exp_q.push_back({de, hs, vs, rgb});
        if (de) exp_addr = 13'(bin);

        pv = 0;
        if (vs && !m_vs_prev) begin
            if (armed) begin
                bb = 0; bm = 0;
                foreach (cand_m[i])
                    if (cand_m[i] > bm || (cand_m[i] == bm && bm > 0 && cand_b[i] < bb)) begin
                        bb = cand_b[i]; bm = cand_m[i];
                    end
                pub_bin = bb; pub_mag = bm; pv = 1;
            end
            armed = 1;
            cand_b.delete(); cand_m.delete();
            m_start = int'(cfg_start_bin); m_step = int'(cfg_step_log2); m_gain = int'(cfg_gain_shift);
        end else if (de && y == PLOT_TOP && !oob) begin
            cand_b.push_back(bin); cand_m.push_back(int'(mem[bin]));
        end
        exp_pk = {pv, 13'(pub_bin), 11'(pub_mag)};
        m_vs_prev = vs;
    endtask

    task automatic vsync();
        repeat (6) cyc(0, 0, 0, rx(), rx());
        repeat (3) cyc(0, 0, 1, rx(), rx());
        repeat (4) cyc(0, 0, 0, rx(), rx());
    endtask

    // One video line over the columns in xs, left to right.
    task automatic line(int y);
        xs.sort();
        repeat (2) cyc(0, 1, 0, rx(), rx());
        cyc(0, 0, 0, rx(), rx());
        foreach (xs[i]) cyc(1, 0, 0, xs[i], y);
        repeat (2) cyc(0, 0, 0, rx(), rx());
    endtask

    task automatic rand_xs(int n);
        xs.delete();
        repeat (n) xs.push_back(int'($urandom_range(0, 1400)));
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 11'(i & 2047);
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(out_rgb), 0);
        chk("rst_de", 32'(out_de), 0);
        chk("rst_vs", 32'(out_vs), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_pv", 32'(peak_valid), 0);
        chk("rst_peak", 32'({peak_bin, peak_mag}), 0);
        rst_n = 1'b1;
        model_reset();

        // Ramp spectrum, column sweep across and beyond the plot rows
        vsync();
        for (int y = 96; y < 616; y++) begin
            xs.delete();
            xs.push_back(300); xs.push_back(0); xs.push_back(64);
            xs.push_back(int'($urandom_range(0, 1400)));
            xs.push_back(int'($urandom_range(0, 1400)));
            line(y);
        end

        // Start bin near the top of the RAM: clamp and oob columns
        cfg_start_bin = 13'd8000;
        vsync();
        foreach (xs[i]) xs[i] = 0;
        for (int k = 0; k < 4; k++) begin
            xs.delete();
            xs.push_back(0); xs.push_back(100); xs.push_back(191); xs.push_back(192);
            xs.push_back(193); xs.push_back(1279); xs.push_back(int'($urandom_range(0, 1400)));
            line(k == 0 ? 100 : (k == 1 ? 300 : (k == 2 ? 611 : 612)));
        end

        // Widest stride
        cfg_step_log2 = 3'd7;
        cfg_start_bin = 13'($urandom_range(0, 8191));
        vsync();
        for (int k = 0; k < 4; k++) begin rand_xs(6); line(k == 0 ? 100 : 150 + k * 100); end

        // Gain changed mid-frame takes effect one frame later
        cfg_start_bin = '0; cfg_step_log2 = '0; cfg_gain_shift = '0;
        mem[500] = 11'd400;
        vsync();
        for (int pass = 0; pass < 3; pass++) begin
            if (pass == 1) cfg_gain_shift = 4'd2;
            if (pass == 2) vsync();
            for (int k = 0; k < 5; k++) begin
                xs.delete(); xs.push_back(500); xs.push_back(int'($urandom_range(0, 1400)));
                line(k == 0 ? 211 : (k == 1 ? 212 : (k == 2 ? 511 : (k == 3 ? 512 : 611))));
            end
        end

        // Two equal peaks: lower bin reported, then an empty frame reports zero
        cfg_gain_shift = '0;
        vsync();
        for (int i = 0; i < 8192; i++) mem[i] = 11'd10;
        mem[50] = 11'd2000; mem[700] = 11'd2000;
        vsync();
        xs.delete();
        for (int x = 0; x < 1280; x++) xs.push_back(x);
        line(100);
        rand_xs(6); line(300);
        vsync();
        vsync();

        // Random spectra and configs
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8192; i++) mem[i] = 11'($urandom_range(0, 2047));
            cfg_start_bin  = 13'($urandom_range(0, 8191));
            cfg_step_log2  = 3'($urandom_range(0, 7));
            cfg_gain_shift = 4'($urandom_range(0, 15));
            if (f == 0) cfg_start_bin = 13'($urandom_range(0, 600));
            vsync();
            for (int k = 0; k < 10; k++) begin
                rand_xs(8);
                line(k == 0 ? 99 : (k == 1 ? 100 : (k == 2 ? 101 : (k == 3 ? 611 :
                     (k == 4 ? 612 : int'($urandom_range(101, 610)))))));
            end
        end
        vsync();

        // Reset in the middle of an active line
        repeat (2) cyc(0, 1, 0, rx(), rx());
        cyc(0, 0, 0, rx(), rx());
        for (int x = 600; x <= 640; x++) cyc(1, 0, 0, x, 300);
        #6;
        chk("pre_rst_de", 32'(out_de), 1);
        #1;
        rst_n = 1'b0;
        in_de = 0; in_hs = 0; in_vs = 0;
        #1;
        chk("arst_de", 32'(out_de), 0);
        chk("arst_rgb", 32'(out_rgb), 0);
        chk("arst_addr", 32'(ram_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cfg_start_bin = '0; cfg_step_log2 = '0; cfg_gain_shift = '0;
        vsync();
        rand_xs(10); line(100);
        rand_xs(5);  line(400);
        vsync();
        vsync();
        repeat (6) cyc(0, 0, 0, rx(), rx());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
